countdown_core: RTL
===================

COUNTDOWN_CORE -- requirements
Module: countdown_core

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port tick_1hz  input  1  one-cycle pulse at 1 Hz, synchronous to clk.
REQ-004 SHALL have port start_pause  input  1  one-cycle pulse; toggles run/pause.
REQ-005 SHALL have port load  input  1  one-cycle pulse; loads the preset value.
REQ-006 SHALL have port preset  input  16  BCD MM:SS as {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
REQ-007 SHALL have ports digit_3, digit_2, digit_1, digit_0  output  4 each  BCD min_tens, min_ones, sec_tens, sec_ones.
REQ-008 SHALL have ports enable_3, enable_2, enable_1, enable_0  output  1 each  per-digit display enable.
REQ-009 SHALL have port running  output  1  high in RUN.
REQ-010 SHALL have port done  output  1  high in DONE.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, RUN, PAUSE, DONE.
REQ-012 SHALL register all outputs; each output changes exactly one clk cycle after the causing input pulse.
REQ-013 SHALL accept load in IDLE, PAUSE and DONE: copy preset into the count and go to IDLE; SHALL ignore load in RUN.
REQ-014 SHALL clamp a loaded digit above 9 to 9, and a loaded sec_tens above 5 to 5.
REQ-015 SHALL, on start_pause: IDLE with nonzero count -> RUN; IDLE with 00:00 -> stay IDLE; RUN -> PAUSE; PAUSE -> RUN; DONE -> no effect.
REQ-016 SHALL decrement the count by one second on each tick_1hz in RUN only.
REQ-017 SHALL decrement as follows: sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; min_ones 0 -> 9 with borrow; min_tens absorbs the borrow.
REQ-018 SHALL go to DONE, with the count held at 00:00, on the tick that makes the count 00:00.
REQ-019 SHALL, when start_pause and tick_1hz arrive together in RUN, go to PAUSE and not apply the tick.
REQ-020 SHALL, when load and start_pause arrive together in a load-accepting state, apply load and ignore start_pause.
REQ-021 SHALL hold the count in IDLE, PAUSE and DONE.
REQ-022 SHALL drive all enables high outside DONE.
REQ-023 SHALL keep the maximum count at 99:59; the count never wraps below 00:00.

Reset
REQ-024 SHALL, while rst is high, set state=IDLE, count=00:00, running=0, done=0 and all enables=1.
REQ-025 SHALL let rst override every other input in the same cycle, including mid-RUN and in DONE.

Configuration
REQ-026 SHALL provide macro COUNTDOWN_BLINK_DONE_EN.
- Defined: in DONE, all four enables toggle together on each tick_1hz, starting from 0 on the first tick after entering DONE.
- Undefined: enables stay 1 in DONE and the blink register is not instantiated.

Structure
REQ-027 SHALL place the state typedef (IDLE/RUN/PAUSE/DONE), BCD digit width 4, and limits SEC_TENS_MAX=5 and DIGIT_MAX=9 in shared package countdown_pkg.
REQ-028 SHALL implement the 4-digit borrow chain as sub-module bcd_time_decrement: combinational, count in -> count out, plus an is_zero flag.

Verification
REQ-029 SHALL cover load of preset 0x0105, start_pause, then 2 ticks -> digits 0,1,0,3 and running=1.
REQ-030 SHALL cover a count of 01:00 in RUN plus 1 tick -> 00:59; a count of 10:00 plus 1 tick -> 09:59.
REQ-031 SHALL cover a count of 00:01 in RUN plus 1 tick -> 00:00 and done=1 next cycle; a further start_pause -> still DONE.
REQ-032 SHALL cover start_pause and tick together in RUN at 00:30 -> PAUSE with count 00:30; 3 ticks -> still 00:30.
REQ-033 SHALL cover load of preset 0xAB7F -> count 99:59; load during RUN -> ignored; start_pause at 00:00 in IDLE -> stays IDLE.
REQ-034 SHALL cover rst asserted mid-RUN at 05:17 -> count 00:00 and IDLE the next cycle.
REQ-035 SHALL cover, with COUNTDOWN_BLINK_DONE_EN defined, DONE plus 2 ticks -> enables 0 then 1.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and limits for the MM:SS countdown core.
// Blink-in-DONE behaviour is selected with COUNTDOWN_BLINK_DONE_EN.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         DIGIT_W      = 4;
    localparam int         COUNT_W      = 4 * DIGIT_W;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] mx
    );
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [COUNT_W-1:0] clamp_preset(
        input logic [COUNT_W-1:0] p
    );
        return {clamp_digit(p[15:12], DIGIT_MAX),
                clamp_digit(p[11:8],  DIGIT_MAX),
                clamp_digit(p[7:4],   SEC_TENS_MAX),
                clamp_digit(p[3:0],   DIGIT_MAX)};
    endfunction

endpackage

// File: rtl/bcd_time_decrement.sv
// Combinational one-second decrement of a BCD MM:SS value.
// Saturates at 00:00; o_is_zero flags a zero input.
module bcd_time_decrement
    import countdown_pkg::*;
(
    input  logic [COUNT_W-1:0] i_count,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_is_zero
);

    logic [DIGIT_W-1:0] w_m1;
    logic [DIGIT_W-1:0] w_m0;
    logic [DIGIT_W-1:0] w_s1;
    logic [DIGIT_W-1:0] w_s0;

    assign o_is_zero = (i_count == '0);

    always_comb begin
        w_m1 = i_count[15:12];
        w_m0 = i_count[11:8];
        w_s1 = i_count[7:4];
        w_s0 = i_count[3:0];
        if (!o_is_zero) begin
            if (w_s0 != '0) begin
                w_s0 = w_s0 - 4'd1;
            end else begin
                w_s0 = DIGIT_MAX;
                if (w_s1 != '0) begin
                    w_s1 = w_s1 - 4'd1;
                end else begin
                    w_s1 = SEC_TENS_MAX;
                    if (w_m0 != '0) begin
                        w_m0 = w_m0 - 4'd1;
                    end else begin
                        w_m0 = DIGIT_MAX;
                        w_m1 = w_m1 - 4'd1;
                    end
                end
            end
        end
        o_count = {w_m1, w_m0, w_s1, w_s0};
    end

endmodule

// File: rtl/countdown_core.sv
// MM:SS countdown timer FSM with registered display outputs.
// Define COUNTDOWN_BLINK_DONE_EN to blink the enables while in DONE.
module countdown_core
    import countdown_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        start_pause,
    input  logic        load,
    input  logic [15:0] preset,
    output logic [3:0]  digit_3,
    output logic [3:0]  digit_2,
    output logic [3:0]  digit_1,
    output logic [3:0]  digit_0,
    output logic        enable_3,
    output logic        enable_2,
    output logic        enable_1,
    output logic        enable_0,
    output logic        running,
    output logic        done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;
    logic [COUNT_W-1:0] w_dec;
    logic               w_zero;
    logic               r_running;
    logic               r_done;
    logic               w_enable;

    bcd_time_decrement u_dec (
        .i_count   (r_count),
        .o_count   (w_dec),
        .o_is_zero (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= (w_state_nxt == DONE);
        end
    end

    // Load wins over start_pause; start_pause wins over a tick in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE: begin
                if (load) begin
                    w_count_nxt = clamp_preset(preset);
                end else if (start_pause && !w_zero) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (start_pause) begin
                    w_state_nxt = PAUSE;
                end else if (tick_1hz) begin
                    w_count_nxt = w_dec;
                    if (w_dec == '0) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            PAUSE: begin
                if (load) begin
                    w_count_nxt = clamp_preset(preset);
                    w_state_nxt = IDLE;
                end else if (start_pause) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    w_count_nxt = clamp_preset(preset);
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef COUNTDOWN_BLINK_DONE_EN
    logic r_blink;

    // Held high until DONE is entered, so the first tick in DONE blanks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink <= 1'b1;
        end else if (w_state_nxt != DONE) begin
            r_blink <= 1'b1;
        end else if (r_state == DONE && tick_1hz) begin
            r_blink <= ~r_blink;
        end
    end

    assign w_enable = r_blink;
`else
    assign w_enable = 1'b1;
`endif

    assign digit_3  = r_count[15:12];
    assign digit_2  = r_count[11:8];
    assign digit_1  = r_count[7:4];
    assign digit_0  = r_count[3:0];
    assign enable_3 = w_enable;
    assign enable_2 = w_enable;
    assign enable_1 = w_enable;
    assign enable_0 = w_enable;
    assign running  = r_running;
    assign done     = r_done;

endmodule
